// File: rtl/gpio_seq_monitor_if.sv
// Push channel that loads expected IO patterns into gpio_seq_monitor.
interface gpio_seq_monitor_if #(
    parameter int WIDTH = 34
);
    logic             push_valid;
    logic [WIDTH-1:0] push_mask;
    logic [WIDTH-1:0] push_value;
    logic             push_ready;

    modport master (output push_valid, output push_mask, output push_value, input push_ready);
    modport slave  (input push_valid, input push_mask, input push_value, output push_ready);
endinterface

// File: rtl/gpio_seq_monitor.sv
// Sequenced, masked IO pattern checker with settle delay, step and global timeouts.
// Optional GPIO_MON_ERRCNT_EN: count step-timeout mismatches and keep going instead of stopping.
module gpio_seq_monitor #(
    parameter int WIDTH          = 34,
    parameter int DEPTH          = 8,
    parameter int SETTLE_CYCLES  = 100,
    parameter int STEP_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       en,
    input  logic [WIDTH-1:0]           io,
    gpio_seq_monitor_if.slave          push,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [1:0]                 cause,
    output logic [$clog2(DEPTH+1)-1:0] step,
    output logic [WIDTH-1:0]           fail_io
`ifdef GPIO_MON_ERRCNT_EN
    ,
    output logic [7:0]                 err_count
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int STEP_W = $clog2(DEPTH + 1);
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1) + 1;
    localparam int SC_W   = $clog2(STEP_CYCLES) + 1;
    localparam int GC_W   = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [CNT_W-1:0]  FIFO_FULL   = CNT_W'(DEPTH);
    localparam logic [STEP_W-1:0] STEP_MAX    = {STEP_W{1'b1}};
    localparam logic [SET_W-1:0]  SETTLE_LIM  = SET_W'(SETTLE_CYCLES);
    localparam logic [SC_W-1:0]   STEP_LIM    = SC_W'(STEP_CYCLES);
    localparam logic [GC_W-1:0]   TIMEOUT_LIM = GC_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISMATCH = 2'd1;
    localparam logic [1:0] CAUSE_EN_LOST  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_EN,
        S_SETTLE,
        S_CHECK,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0]  io_q;
    logic [WIDTH-1:0]  mem_mask  [DEPTH];
    logic [WIDTH-1:0]  mem_value [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_not_full, fifo_empty, push_fire, pop, match;

    logic [SET_W-1:0]  settle_cnt, settle_nx, settle_inc;
    logic [SC_W-1:0]   step_cnt, step_cnt_nx, step_cnt_inc;
    logic [GC_W-1:0]   glob_cnt, glob_nx, glob_inc;
    logic [STEP_W-1:0] step_nx, step_inc;
    logic [1:0]        cause_nx;
    logic [WIDTH-1:0]  fail_io_nx;
    logic              finishing;
`ifdef GPIO_MON_ERRCNT_EN
    logic [7:0]        err_nx;
`endif

    assign fifo_not_full   = (count != FIFO_FULL);
    assign fifo_empty      = (count == '0);
    assign push.push_ready = fifo_not_full;
    assign push_fire       = push.push_valid && fifo_not_full;
    assign match           = ((io_q ^ mem_value[rd_ptr]) & mem_mask[rd_ptr]) == '0;

    assign busy = (state == S_WAIT_EN) || (state == S_SETTLE) || (state == S_CHECK);
    assign done = (state == S_PASS) || (state == S_FAIL) || (state == S_TIMEOUT);
    assign pass = (state == S_PASS);

    assign settle_inc   = (settle_cnt >= SETTLE_LIM) ? settle_cnt : settle_cnt + 1'b1;
    assign step_cnt_inc = (step_cnt >= STEP_LIM) ? step_cnt : step_cnt + 1'b1;
    assign glob_inc     = (glob_cnt >= TIMEOUT_LIM) ? glob_cnt : glob_cnt + 1'b1;
    assign step_inc     = (step == STEP_MAX) ? step : step + 1'b1;

    // Storage is not reset; emptiness is tracked solely by the pointers and count.
    always_ff @(posedge clock) begin
        if (push_fire) begin
            mem_mask[wr_ptr]  <= push.push_mask;
            mem_value[wr_ptr] <= push.push_value;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state      <= S_IDLE;
            io_q       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            settle_cnt <= '0;
            step_cnt   <= '0;
            glob_cnt   <= '0;
            step       <= '0;
            cause      <= CAUSE_NONE;
            fail_io    <= '0;
`ifdef GPIO_MON_ERRCNT_EN
            err_count  <= '0;
`endif
        end else begin
            state      <= state_nx;
            io_q       <= io;
            settle_cnt <= settle_nx;
            step_cnt   <= step_cnt_nx;
            glob_cnt   <= glob_nx;
            step       <= step_nx;
            cause      <= cause_nx;
            fail_io    <= fail_io_nx;
`ifdef GPIO_MON_ERRCNT_EN
            err_count  <= err_nx;
`endif
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        pop         = 1'b0;
        finishing   = 1'b0;
        settle_nx   = settle_cnt;
        step_cnt_nx = step_cnt;
        glob_nx     = glob_cnt;
        step_nx     = step;
        cause_nx    = cause;
        fail_io_nx  = fail_io;
`ifdef GPIO_MON_ERRCNT_EN
        err_nx      = err_count;
`endif
        case (state)
            S_IDLE, S_PASS, S_FAIL, S_TIMEOUT: begin
                if (start) begin
                    state_nx    = S_WAIT_EN;
                    settle_nx   = '0;
                    step_cnt_nx = '0;
                    glob_nx     = '0;
                    step_nx     = '0;
                    cause_nx    = CAUSE_NONE;
                    fail_io_nx  = '0;
`ifdef GPIO_MON_ERRCNT_EN
                    err_nx      = '0;
`endif
                end
            end
            S_WAIT_EN: begin
                if (en) begin
                    settle_nx = '0;
                    state_nx  = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!en) begin
                    state_nx   = S_FAIL;
                    cause_nx   = CAUSE_EN_LOST;
                    fail_io_nx = io_q;
                    finishing  = 1'b1;
                end else begin
                    settle_nx = settle_inc;
                    if (settle_inc >= SETTLE_LIM) state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                // Losing enable outranks any compare result in the same cycle.
                if (!en) begin
                    state_nx   = S_FAIL;
                    cause_nx   = CAUSE_EN_LOST;
                    fail_io_nx = io_q;
                    finishing  = 1'b1;
                end else if (fifo_empty) begin
                    finishing = 1'b1;
`ifdef GPIO_MON_ERRCNT_EN
                    if (err_count != '0) begin
                        state_nx = S_FAIL;
                        cause_nx = CAUSE_MISMATCH;
                    end else begin
                        state_nx = S_PASS;
                    end
`else
                    state_nx = S_PASS;
`endif
                end else if (match) begin
                    pop         = 1'b1;
                    step_nx     = step_inc;
                    step_cnt_nx = '0;
                end else if (step_cnt_inc >= STEP_LIM) begin
`ifdef GPIO_MON_ERRCNT_EN
                    pop         = 1'b1;
                    step_nx     = step_inc;
                    step_cnt_nx = '0;
                    err_nx      = (err_count == 8'hFF) ? err_count : err_count + 1'b1;
                    if (err_count == '0) fail_io_nx = io_q;
`else
                    state_nx    = S_FAIL;
                    cause_nx    = CAUSE_MISMATCH;
                    fail_io_nx  = io_q;
                    step_cnt_nx = step_cnt_inc;
                    finishing   = 1'b1;
`endif
                end else begin
                    step_cnt_nx = step_cnt_inc;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // The global limit only wins when nothing else ends the run this cycle.
        if (busy) begin
            glob_nx = glob_inc;
            if (!finishing && (glob_inc >= TIMEOUT_LIM)) begin
                state_nx   = S_TIMEOUT;
                cause_nx   = CAUSE_TIMEOUT;
                fail_io_nx = io_q;
            end
        end
    end

endmodule

// File: tb/tb_gpio_seq_monitor.sv
// Directed self-checking bench for gpio_seq_monitor (WIDTH=8, DEPTH=4, SETTLE=4, STEP=10, TIMEOUT=200).
// Build with GPIO_MON_ERRCNT_EN defined to also exercise the error-count path.
module tb_gpio_seq_monitor;

    localparam int WIDTH          = 8;
    localparam int DEPTH          = 4;
    localparam int SETTLE_CYCLES  = 4;
    localparam int STEP_CYCLES    = 10;
    localparam int TIMEOUT_CYCLES = 200;

    logic             clock = 1'b0;
    logic             reset;
    logic             clear;
    logic             start;
    logic             en;
    logic [WIDTH-1:0] io;
    logic             busy;
    logic             done;
    logic             pass;
    logic [1:0]       cause;
    logic [2:0]       step;
    logic [WIDTH-1:0] fail_io;
`ifdef GPIO_MON_ERRCNT_EN
    logic [7:0]       err_count;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    gpio_seq_monitor_if #(.WIDTH(WIDTH)) bus ();

    gpio_seq_monitor #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .STEP_CYCLES(STEP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .clear(clear),
        .start(start),
        .en(en),
        .io(io),
        .push(bus),
        .busy(busy),
        .done(done),
        .pass(pass),
        .cause(cause),
        .step(step),
        .fail_io(fail_io)
`ifdef GPIO_MON_ERRCNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en_v, input logic [WIDTH-1:0] io_v);
        en = en_v;
        io = io_v;
    endtask

    task automatic pushEntry(input logic [WIDTH-1:0] mask, input logic [WIDTH-1:0] value);
        bus.push_valid = 1'b1;
        bus.push_mask  = mask;
        bus.push_value = value;
        tick();
        bus.push_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic waitStep(input logic [2:0] target, input int budget, input string tag);
        int n = 0;
        while (step != target && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, {29'd0, step}, {29'd0, target});
    endtask

    initial begin
        logic [WIDTH-1:0] seq_vals [4];
        seq_vals = '{8'h11, 8'h22, 8'h33, 8'h44};

        reset = 1'b1;
        clear = 1'b0;
        start = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_mask  = '0;
        bus.push_value = '0;
        applyStimulus(1'b0, 8'h00);
        tick(2);
        reset = 1'b0;
        tick();

        $display("[TB] reset state");
        checkOutput("rst_push_ready", {31'd0, bus.push_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_pass", {31'd0, pass}, 32'd0);
        checkOutput("rst_cause", {30'd0, cause}, 32'd0);
        checkOutput("rst_step", {29'd0, step}, 32'd0);
        checkOutput("rst_fail_io", {24'd0, fail_io}, 32'd0);

        $display("[TB] happy path");
        pushEntry(8'hFF, 8'hA5);
        pushEntry(8'h0F, 8'h03);
        applyStimulus(1'b0, 8'hA5);
        pulseStart();
        checkOutput("happy_busy", {31'd0, busy}, 32'd1);
        tick(4);
        applyStimulus(1'b1, 8'hA5);
        waitStep(3'd1, 30, "happy_step1");
        applyStimulus(1'b1, 8'h13);
        waitDone(200, "happy_done");
        checkOutput("happy_pass", {31'd0, pass}, 32'd1);
        checkOutput("happy_cause", {30'd0, cause}, 32'd0);
        checkOutput("happy_step", {29'd0, step}, 32'd2);
        checkOutput("happy_busy_low", {31'd0, busy}, 32'd0);

        $display("[TB] step-timeout mismatch");
        pushEntry(8'hFF, 8'hA5);
        applyStimulus(1'b1, 8'hA4);
        pulseStart();
        tick(14);
        checkOutput("mis_still_busy", {31'd0, busy}, 32'd1);
`ifdef GPIO_MON_ERRCNT_EN
        tick(2);
        checkOutput("mis_step", {29'd0, step}, 32'd1);
        checkOutput("mis_err_count", {24'd0, err_count}, 32'd1);
`else
        tick(1);
        checkOutput("mis_step", {29'd0, step}, 32'd0);
`endif
        checkOutput("mis_done", {31'd0, done}, 32'd1);
        checkOutput("mis_pass", {31'd0, pass}, 32'd0);
        checkOutput("mis_cause", {30'd0, cause}, 32'd1);
        checkOutput("mis_fail_io", {24'd0, fail_io}, 32'h0000_00A4);

        $display("[TB] restart after fail");
`ifdef GPIO_MON_ERRCNT_EN
        pushEntry(8'hFF, 8'hA5);
`endif
        applyStimulus(1'b1, 8'hA5);
        pulseStart();
        checkOutput("restart_done_clr", {31'd0, done}, 32'd0);
        checkOutput("restart_cause_clr", {30'd0, cause}, 32'd0);
        checkOutput("restart_fail_io_clr", {24'd0, fail_io}, 32'd0);
        waitDone(50, "restart_done");
        checkOutput("restart_pass", {31'd0, pass}, 32'd1);
        checkOutput("restart_step", {29'd0, step}, 32'd1);

        $display("[TB] enable lost during settle");
        pushEntry(8'hFF, 8'h55);
        applyStimulus(1'b0, 8'hA5);
        pulseStart();
        tick(2);
        applyStimulus(1'b1, 8'hA5);
        tick(2);
        checkOutput("enlost_busy", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, 8'hA5);
        tick();
        checkOutput("enlost_done", {31'd0, done}, 32'd1);
        checkOutput("enlost_pass", {31'd0, pass}, 32'd0);
        checkOutput("enlost_cause", {30'd0, cause}, 32'd2);
        checkOutput("enlost_fail_io", {24'd0, fail_io}, 32'h0000_00A5);

        $display("[TB] global timeout");
        pulseStart();
        tick(199);
        checkOutput("tmo_busy_before", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("tmo_done", {31'd0, done}, 32'd1);
        checkOutput("tmo_cause", {30'd0, cause}, 32'd3);
        checkOutput("tmo_busy", {31'd0, busy}, 32'd0);
        checkOutput("tmo_pass", {31'd0, pass}, 32'd0);
        pulseClear();
        checkOutput("tmo_clear_done", {31'd0, done}, 32'd0);
        checkOutput("tmo_clear_cause", {30'd0, cause}, 32'd0);

        $display("[TB] fifo boundaries");
        bus.push_valid = 1'b1;
        bus.push_mask  = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            bus.push_value = (k < 4) ? seq_vals[k] : 8'h55;
            tick();
            if (k == 2) checkOutput("fifo_ready_after3", {31'd0, bus.push_ready}, 32'd1);
            if (k == 3) checkOutput("fifo_ready_after4", {31'd0, bus.push_ready}, 32'd0);
            if (k == 4) checkOutput("fifo_ready_after5", {31'd0, bus.push_ready}, 32'd0);
        end
        bus.push_valid = 1'b0;
        applyStimulus(1'b1, seq_vals[0]);
        pulseStart();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, seq_vals[k]);
            waitStep(3'(k + 1), 30, $sformatf("fifo_step%0d", k + 1));
        end
        waitDone(20, "fifo_done");
        checkOutput("fifo_pass", {31'd0, pass}, 32'd1);
        checkOutput("fifo_step_final", {29'd0, step}, 32'd4);
        checkOutput("fifo_ready_empty", {31'd0, bus.push_ready}, 32'd1);

        $display("[TB] clear mid-check");
        pushEntry(8'hFF, 8'h77);
        applyStimulus(1'b1, 8'h00);
        pulseStart();
        tick(8);
        checkOutput("clr_busy_before", {31'd0, busy}, 32'd1);
        pulseClear();
        checkOutput("clr_busy", {31'd0, busy}, 32'd0);
        checkOutput("clr_done", {31'd0, done}, 32'd0);
        checkOutput("clr_push_ready", {31'd0, bus.push_ready}, 32'd1);
        checkOutput("clr_step", {29'd0, step}, 32'd0);
        pulseStart();
        waitDone(20, "clr_rerun_done");
        checkOutput("clr_rerun_pass", {31'd0, pass}, 32'd1);
        checkOutput("clr_rerun_step", {29'd0, step}, 32'd0);

        $display("[TB] match coinciding with enable drop");
        pushEntry(8'hFF, 8'h66);
        applyStimulus(1'b1, 8'h00);
        pulseStart();
        tick(5);
        applyStimulus(1'b1, 8'h66);
        tick();
        applyStimulus(1'b0, 8'h66);
        tick();
        checkOutput("prio_done", {31'd0, done}, 32'd1);
        checkOutput("prio_cause", {30'd0, cause}, 32'd2);
        checkOutput("prio_step", {29'd0, step}, 32'd0);
        checkOutput("prio_fail_io", {24'd0, fail_io}, 32'h0000_0066);

`ifdef GPIO_MON_ERRCNT_EN
        $display("[TB] error count with two bad entries");
        pulseClear();
        pushEntry(8'hFF, 8'h01);
        pushEntry(8'hFF, 8'h02);
        pushEntry(8'hFF, 8'hEE);
        applyStimulus(1'b1, 8'hEE);
        pulseStart();
        waitDone(100, "errcnt_done");
        checkOutput("errcnt_pass", {31'd0, pass}, 32'd0);
        checkOutput("errcnt_cause", {30'd0, cause}, 32'd1);
        checkOutput("errcnt_count", {24'd0, err_count}, 32'd2);
        checkOutput("errcnt_step", {29'd0, step}, 32'd3);
        checkOutput("errcnt_fail_io", {24'd0, fail_io}, 32'h0000_00EE);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_seq_monitor.md
Name: gpio_seq_monitor

Overview:
Synthesizable, parametrised self-checking monitor for user-project IO. It waits for a design enable, allows a settle delay, then checks a queued sequence of masked expected IO patterns in order. Each step and the whole run have a cycle timeout, and the block reports pass, fail or timeout with a cause code and the IO value captured at failure. It sits beside a team wrapper, on-chip or in a bench, and replaces fixed-delay pass/fail checking.

Parameters:
WIDTH, 34, number of monitored IO bits
DEPTH, 8, expected-pattern FIFO entries (power of 2, >=2)
SETTLE_CYCLES, 100, cycles between enable seen and first compare (0 allowed)
STEP_CYCLES, 1000, max cycles waiting for the head pattern to match (>=1)
TIMEOUT_CYCLES, 100000, global cycle limit from start (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous flush: empties FIFO, returns to IDLE, clears results
start  in  1  one-cycle pulse, begins a run
en  in  1  design-under-check enable
io  in  WIDTH  monitored IO bits
push_valid  in  1  expected-entry write strobe
push_mask  in  WIDTH  compare mask (1 = check bit)
push_value  in  WIDTH  expected value
push_ready  out  1  FIFO not full
busy  out  1  run in progress (WAIT_EN/SETTLE/CHECK)
done  out  1  run finished (PASS/FAIL/TIMEOUT)
pass  out  1  run finished successfully
cause  out  2  0 none, 1 mismatch, 2 enable lost, 3 global timeout
step  out  $clog2(DEPTH+1)  entries matched in the current run
fail_io  out  WIDTH  registered io at the failing cycle

Behaviour:
- Reset or clear: state IDLE, FIFO empty, push_ready=1, busy=0, done=0, pass=0, cause=0, step=0, fail_io=0, all counters 0. Reset has priority over clear. Clear has priority over all other inputs.
- io is registered once (io_q). All compares use io_q, which gives 1 cycle of input latency.
- FIFO: push is accepted when push_valid && push_ready, in any state. A push while full is dropped with no side effect. Pop happens only on a CHECK match. A push and a pop in the same cycle on a full FIFO: the pop frees a slot, but push_ready reflects the pre-pop state, so the push is dropped.
- States: IDLE, WAIT_EN, SETTLE, CHECK, PASS, FAIL, TIMEOUT.
- IDLE or any terminal state, start=1: go to WAIT_EN. Clear done, pass, cause, step, global counter, step counter and fail_io. The FIFO is retained. start is ignored while busy.
- WAIT_EN: when en=1, go to SETTLE with the settle counter at 0. If SETTLE_CYCLES=0, go directly to CHECK.
- SETTLE: the counter increments every cycle. After SETTLE_CYCLES cycles in SETTLE, go to CHECK.
- CHECK: if the FIFO is empty, go to PASS.
  - Match, ((io_q ^ head.value) & head.mask)==0: pop, step+1, step counter to 0. A matched last entry goes to PASS on the next cycle (empty check).
  - No match: step counter +1. When it reaches STEP_CYCLES, go to FAIL with cause=1 and fail_io=io_q.
  - mask=0 always matches.
- en deasserted in SETTLE or CHECK: go to FAIL with cause=2 and fail_io=io_q. This takes priority over match and mismatch in the same cycle.
- Global counter counts every cycle in WAIT_EN/SETTLE/CHECK. When it reaches TIMEOUT_CYCLES, go to TIMEOUT with cause=3 and fail_io=io_q. This fires only if no other terminal transition occurs in that cycle; FAIL and PASS take priority.
- Terminal states: done=1, busy=0. pass=1 only in PASS. Outputs hold until start, clear or reset.
- Counters saturate and never wrap. Widths come from $clog2 of the respective limit plus 1.

Optional Feature:
GPIO_MON_ERRCNT_EN
- Defined:
  - A step-timeout mismatch pops the head entry, increments the err_count output (8 bits, saturating at 255), and continues.
  - fail_io captures the first mismatch only.
  - At FIFO empty: PASS if err_count==0, else FAIL with cause=1.
  - Enable loss and global timeout behave as without the macro.
  - err_count clears on start, clear and reset.
- Undefined: the first mismatch terminates the run, and the err_count port does not exist.

Test Plan:
All scenarios use WIDTH=8, DEPTH=4, SETTLE_CYCLES=4, STEP_CYCLES=10, TIMEOUT_CYCLES=200.
1. Happy path: push {FF,A5},{0F,03}; start; en=1 at cycle 5; io=A5, then 13 later -> pass=1, cause=0, step=2, done within 200 cycles.
2. Mismatch: push {FF,A5}; start; en=1; io held at A4 -> FAIL 10 cycles after entering CHECK, cause=1, fail_io=A4, step=0.
3. Enable lost: push {FF,55}; start; en=1, dropped to 0 during SETTLE -> cause=2, pass=0, done=1.
4. Global timeout: push one entry; start; en held 0 -> TIMEOUT at 200 cycles after start, cause=3, busy=0.
5. FIFO boundaries: push 5 entries back to back -> the 5th is dropped and push_ready=0 after the 4th. Clear mid-CHECK -> IDLE, push_ready=1, done=0.
6. Restart and priority: after FAIL, start again with a matching io -> PASS with results cleared. A match coinciding with en falling -> cause=2. With GPIO_MON_ERRCNT_EN, two bad entries out of three -> FAIL, err_count=2, step=3.
